regfile_32x64: RTL and testbench

// - 32-entry x 64-bit register file: storage, write-address decode, two read ports.
// - Read ports are built from mux32to1_64bit instances fed by the internal register array.
// - Sits between writeback (write port) and operand fetch in decode (read ports).
// - Entry 31 (XZR) is hardwired to zero.

---
 rtl/regfile_32x64.sv | 115 +++++++++++
 tb/tb_regfile_32x64.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: one write port, two combinational read ports, entry ZERO_REG reads as zero.
// Define REGFILE_BYPASS_EN to forward WriteData to a read port that hits the entry being written.

module mux32to1_64bit (
    input  logic [4:0]  sel_i,
    input  logic [63:0] data_i [32],
    output logic [63:0] data_o
);
    assign data_o = data_i[sel_i];
endmodule

`ifdef REGFILE_BYPASS_EN
module mux2to1_Nbit #(
    parameter int N = 64
) (
    input  logic         sel_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule
`endif

module regfile_32x64 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);
    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic [31:0]      wr_onehot;
    logic [WIDTH-1:0] rd_array [32];
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;

    always_comb begin
        wr_onehot = '0;
        if (RegWrite && (WriteRegister != ZERO_IDX)) begin
            wr_onehot[WriteRegister] = 1'b1;
        end
    end

    // The zero entry is a constant tie-off, so it never holds state.
    for (genvar g = 0; g < 32; g++) begin : g_entry
        if (g == ZERO_REG) begin : g_zero
            assign rd_array[g] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] entry_q;
            logic [WIDTH-1:0] entry_d;

            assign entry_d = wr_onehot[g] ? WriteData : entry_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign rd_array[g] = entry_q;
        end
    end

    mux32to1_64bit u_rd_mux1 (
        .sel_i  (ReadRegister1),
        .data_i (rd_array),
        .data_o (rd_data1)
    );

    mux32to1_64bit u_rd_mux2 (
        .sel_i  (ReadRegister2),
        .data_i (rd_array),
        .data_o (rd_data2)
    );

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    logic fwd1;
    logic fwd2;

    // Forwarding is gated by reset so reads stay zero while reset is held.
    assign wr_live = reset & RegWrite & (WriteRegister != ZERO_IDX);
    assign fwd1    = wr_live & (&(ReadRegister1 ~^ WriteRegister));
    assign fwd2    = wr_live & (&(ReadRegister2 ~^ WriteRegister));

    mux2to1_Nbit #(.N(WIDTH)) u_fwd1 (
        .sel_i (fwd1),
        .a_i   (rd_data1),
        .b_i   (WriteData),
        .y_o   (ReadData1)
    );

    mux2to1_Nbit #(.N(WIDTH)) u_fwd2 (
        .sel_i (fwd2),
        .a_i   (rd_data2),
        .b_i   (WriteData),
        .y_o   (ReadData2)
    );
`else
    assign ReadData1 = rd_data1;
    assign ReadData2 = rd_data2;
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: directed vector table, directed corner sequences,
// and randomized traffic against an array-based model of the register file.

module tb_regfile_32x64;
    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int total = 0;
    int bad   = 0;

    logic [63:0] model [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [63:0] e1;
        logic [63:0] e2;
    } vec_t;

    vec_t vecs [7];

    regfile_32x64 dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mread(input logic [4:0] idx);
        return (idx == 5'd31) ? 64'h0 : model[idx];
    endfunction

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = a;
        WriteData     = d;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        if (a != 5'd31) model[a] = d;
    endtask

    task automatic read_chk(input string nm, input logic [4:0] a, input logic [4:0] b);
        ReadRegister1 = a;
        ReadRegister2 = b;
        #1;
        check({nm, "_p1"}, ReadData1, mread(a));
        check({nm, "_p2"}, ReadData2, mread(b));
    endtask

    initial begin
        logic [63:0] exp1, exp2;
        logic        fwd1, fwd2;

        vecs[0] = '{1'b1, 5'd3,  64'hA5A5_0000_1111_2222, 5'd3,  5'd30, 64'hA5A5_0000_1111_2222, 64'h0};
        vecs[1] = '{1'b1, 5'd30, 64'h0BAD_F00D_1234_5678, 5'd3,  5'd30, 64'hA5A5_0000_1111_2222, 64'h0BAD_F00D_1234_5678};
        vecs[2] = '{1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 5'd30, 5'd3,  64'h0BAD_F00D_1234_5678, 64'hA5A5_0000_1111_2222};
        vecs[3] = '{1'b1, 5'd31, 64'hDEAD_BEEF_CAFE_F00D, 5'd31, 5'd31, 64'h0, 64'h0};
        vecs[4] = '{1'b1, 5'd3,  64'hC0C0_C0C0_C0C0_C0C0, 5'd3,  5'd3,  64'hC0C0_C0C0_C0C0_C0C0, 64'hC0C0_C0C0_C0C0_C0C0};
        vecs[5] = '{1'b1, 5'd3,  64'h0000_0000_0000_00D1, 5'd3,  5'd30, 64'h0000_0000_0000_00D1, 64'h0BAD_F00D_1234_5678};
        vecs[6] = '{1'b1, 5'd0,  64'hEEEE_0000_EEEE_0001, 5'd0,  5'd31, 64'hEEEE_0000_EEEE_0001, 64'h0};

        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset = 1'b0; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'h0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd17;
        #2;
        check("rst_p1", ReadData1, 64'h0);
        check("rst_p2", ReadData2, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table: values read just after the edge that applies each row.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            RegWrite = vecs[i].we; WriteRegister = vecs[i].wa; WriteData = vecs[i].wd;
            ReadRegister1 = vecs[i].r1; ReadRegister2 = vecs[i].r2;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_p1", i), ReadData1, vecs[i].e1);
            check($sformatf("vec%0d_p2", i), ReadData2, vecs[i].e2);
            if (vecs[i].we && vecs[i].wa != 5'd31) model[vecs[i].wa] = vecs[i].wd;
        end
        RegWrite = 1'b0;

        for (int i = 0; i < 31; i++) write_reg(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
        for (int i = 0; i < 32; i++) read_chk($sformatf("sweep%0d", i), 5'(i), 5'(31 - i));
        check("sweep_r30_lit", model[30], 64'h1E1E_1E1E_1E1E_1E1E);

        write_reg(5'd31, 64'hDEAD_BEEF_CAFE_F00D);
        read_chk("zero_reg", 5'd31, 5'd31);

        @(negedge clk);
        RegWrite = 1'b0; WriteRegister = 5'd5; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk);
        #1;
        ReadRegister1 = 5'd5;
        #1;
        check("gate_r5", ReadData1, 64'h0505_0505_0505_0505);

        read_chk("dual", 5'd3, 5'd30);
        read_chk("dual_swap", 5'd30, 5'd3);

        write_reg(5'd7, 64'h1);
        @(negedge clk);
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 64'h2;
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7;
        #2;
`ifdef REGFILE_BYPASS_EN
        check("haz_pre_p1", ReadData1, 64'h2);
        check("haz_pre_p2", ReadData2, 64'h2);
`else
        check("haz_pre_p1", ReadData1, 64'h1);
        check("haz_pre_p2", ReadData2, 64'h1);
`endif
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        model[7] = 64'h2;
        #1;
        check("haz_post_p1", ReadData1, 64'h2);
        check("haz_post_p2", ReadData2, 64'h2);

        // Mid-cycle reset with a write held across an edge while reset is low.
        @(negedge clk);
        #1;
        reset = 1'b0;
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(31 - i);
            #1;
            check($sformatf("rst_mid%0d_p1", i), ReadData1, 64'h0);
            check($sformatf("rst_mid%0d_p2", i), ReadData2, 64'h0);
        end
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        @(negedge clk);
        RegWrite = 1'b0;
        reset = 1'b1;
        read_chk("rst_drop_r4", 5'd4, 5'd3);
        write_reg(5'd9, 64'h9999_0000_9999_0000);
        read_chk("post_rst_w", 5'd9, 5'd4);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            RegWrite      = 1'($urandom_range(0, 1));
            WriteRegister = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            WriteData     = {$urandom, $urandom};
            ReadRegister1 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
`ifdef REGFILE_BYPASS_EN
            fwd1 = RegWrite && WriteRegister != 5'd31 && ReadRegister1 == WriteRegister;
            fwd2 = RegWrite && WriteRegister != 5'd31 && ReadRegister2 == WriteRegister;
`else
            fwd1 = 1'b0;
            fwd2 = 1'b0;
`endif
            exp1 = fwd1 ? WriteData : mread(ReadRegister1);
            exp2 = fwd2 ? WriteData : mread(ReadRegister2);
            #2;
            check($sformatf("rnd%0d_p1", n), ReadData1, exp1);
            check($sformatf("rnd%0d_p2", n), ReadData2, exp2);
            @(posedge clk);
            #1;
            if (RegWrite && WriteRegister != 5'd31) model[WriteRegister] = WriteData;
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) read_chk($sformatf("final%0d", i), 5'(i), 5'(i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
